// File: rtl/rv_barrier_ctrl.sv
// Per-core barrier manager: parks arriving warps per barrier entry and
// releases the whole group with a one-cycle pulse once the programmed
// warp count has arrived. Flags duplicate arrivals and size mismatches.
module rv_barrier_ctrl #(
   parameter int unsigned NUM_WARPS    = 4,
   parameter int unsigned NUM_BARRIERS = 4,
   parameter int unsigned NW_BITS      = 2,
   parameter int unsigned NB_BITS      = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    bar_valid,
   input  logic [NW_BITS-1:0]      bar_wid,
   input  logic [NB_BITS-1:0]      bar_id,
   input  logic [NW_BITS-1:0]      bar_size_m1,
   output logic                    release_valid,
   output logic [NB_BITS-1:0]      release_id,
   output logic [NUM_WARPS-1:0]    release_wmask,
   output logic [NUM_WARPS-1:0]    stalled_wmask,
   output logic [NUM_BARRIERS-1:0] barrier_busy,
   output logic                    dup_err,
   output logic                    size_err
);

   // Barrier table state
   logic [NW_BITS-1:0]   count_q [NUM_BARRIERS];
   logic [NW_BITS-1:0]   count_d [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];
   logic [NW_BITS-1:0]   size_q  [NUM_BARRIERS];
   logic [NW_BITS-1:0]   size_d  [NUM_BARRIERS];

   // Registered pulse outputs
   logic                 release_valid_q, release_valid_d;
   logic [NB_BITS-1:0]   release_id_q, release_id_d;
   logic [NUM_WARPS-1:0] release_wmask_q, release_wmask_d;
   logic                 dup_err_q, dup_err_d;
   logic                 size_err_q, size_err_d;

   // Classification of the incoming event against pre-update state
   logic [NUM_WARPS-1:0] wid_oh;
   logic                 entry_idle;
   logic [NW_BITS-1:0]   eff_size;
   logic                 hit;

   assign wid_oh     = NUM_WARPS'(1) << bar_wid;
   assign entry_idle = (count_q[bar_id] == '0);
   assign eff_size   = entry_idle ? bar_size_m1 : size_q[bar_id];
   assign hit        = (eff_size == count_q[bar_id]);

   // Stall mask and busy flags derived from the table so they track releases exactly
   always_comb begin
      stalled_wmask = '0;
      barrier_busy  = '0;
      for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
         stalled_wmask   = stalled_wmask | wmask_q[b];
         barrier_busy[b] = (count_q[b] != '0);
      end
   end

   // Next-state: drop duplicates, complete on hit, otherwise park the warp
   always_comb begin
      count_d         = count_q;
      wmask_d         = wmask_q;
      size_d          = size_q;
      release_valid_d = 1'b0;
      release_id_d    = '0;
      release_wmask_d = '0;
      dup_err_d       = 1'b0;
      size_err_d      = 1'b0;
      if (bar_valid) begin
         if (stalled_wmask[bar_wid]) begin
            dup_err_d = 1'b1;
         end else begin
            size_err_d = !entry_idle && (bar_size_m1 != size_q[bar_id]);
            if (hit) begin
               release_valid_d = 1'b1;
               release_id_d    = bar_id;
               release_wmask_d = wmask_q[bar_id] | wid_oh;
               count_d[bar_id] = '0;
               wmask_d[bar_id] = '0;
               size_d[bar_id]  = '0;
            end else begin
               count_d[bar_id] = count_q[bar_id] + NW_BITS'(1);
               wmask_d[bar_id] = wmask_q[bar_id] | wid_oh;
               if (entry_idle) begin
                  size_d[bar_id] = bar_size_m1;
               end
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
            count_q[b] <= '0;
            wmask_q[b] <= '0;
            size_q[b]  <= '0;
         end
         release_valid_q <= 1'b0;
         release_id_q    <= '0;
         release_wmask_q <= '0;
         dup_err_q       <= 1'b0;
         size_err_q      <= 1'b0;
      end else begin
         count_q         <= count_d;
         wmask_q         <= wmask_d;
         size_q          <= size_d;
         release_valid_q <= release_valid_d;
         release_id_q    <= release_id_d;
         release_wmask_q <= release_wmask_d;
         dup_err_q       <= dup_err_d;
         size_err_q      <= size_err_d;
      end
   end

   assign release_valid = release_valid_q;
   assign release_id    = release_id_q;
   assign release_wmask = release_wmask_q;
   assign dup_err       = dup_err_q;
   assign size_err      = size_err_q;

endmodule
